// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA decode types: opcode/funct encodings, command bundles that
// execute consumes, and the immediate generator used by the decoder.
package rv32ima_pkg;

   localparam int XLEN         = 32;
   localparam int LDST_WIDTH_W = 2;

   typedef logic [XLEN-1:0] word_t;
   typedef logic [4:0]      reg_t;

   // ALU operations; the AMO-only entries combine the loaded word with rs2
   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV,
      ALU_DIVU, ALU_REM, ALU_REMU, ALU_SWAP, ALU_MIN, ALU_MAX, ALU_MINU,
      ALU_MAXU
   } aluop_t;

   // ALU operand sources: a/b = rs1/rs2, rs1/imm, pc/imm, zero/imm
   typedef enum logic [1:0] {
      INSEL_R2R, INSEL_R2I, INSEL_PC2I, INSEL_Z2I
   } alu_insel_t;

   typedef enum logic [2:0] {
      INST_R, INST_I, INST_S, INST_B, INST_U, INST_J
   } inst_t;

   typedef enum logic [3:0] {
      CTRL_NONE, CTRL_BEQ, CTRL_BNE, CTRL_BLT, CTRL_BGE, CTRL_BLTU, CTRL_BGEU,
      CTRL_JAL, CTRL_JALR, CTRL_FENCE, CTRL_ECALL, CTRL_EBREAK
   } bcontrol_t;

   // Register write-back source: ALU result, memory data, or pc+4 (links)
   typedef enum logic [1:0] {
      WSEL_ALU, WSEL_MEM, WSEL_PC4
   } rf_wsel_t;

   typedef struct packed {
      aluop_t     aluop;
      alu_insel_t insel;
   } alu_cmd_t;

   typedef struct packed {
      reg_t     rs1;
      reg_t     rs2;
      reg_t     rd;
      logic     wen;
      rf_wsel_t wsel;
   } rf_cmd_t;

   typedef struct packed {
      logic                    wen;
      logic                    ren;
      logic                    load_unsigned;
      logic [LDST_WIDTH_W-1:0] width;   // 0 byte, 1 half, 2 word
   } dmem_cmd_t;

   typedef struct packed {
      alu_cmd_t  alu;
      rf_cmd_t   rf;
      dmem_cmd_t dmem;
      bcontrol_t control;
      inst_t     inst_type;
      word_t     imm32;
      logic      illegal;
   } decoded_inst_t;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_AMO     = 7'b0101111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_AMO_W = 3'b010;

   localparam logic [4:0] F5_LR      = 5'b00010;
   localparam logic [4:0] F5_SC      = 5'b00011;
   localparam logic [4:0] F5_AMOSWAP = 5'b00001;
   localparam logic [4:0] F5_AMOADD  = 5'b00000;
   localparam logic [4:0] F5_AMOXOR  = 5'b00100;
   localparam logic [4:0] F5_AMOAND  = 5'b01100;
   localparam logic [4:0] F5_AMOOR   = 5'b01000;
   localparam logic [4:0] F5_AMOMIN  = 5'b10000;
   localparam logic [4:0] F5_AMOMAX  = 5'b10100;
   localparam logic [4:0] F5_AMOMINU = 5'b11000;
   localparam logic [4:0] F5_AMOMAXU = 5'b11100;

   // Sign-extended immediate for a format; the opcode bits never feed it
   function automatic word_t imm_gen(input logic [31:7] i, input inst_t fmt);
      word_t imm;
      case (fmt)
         INST_I:  imm = {{20{i[31]}}, i[31:20]};
         INST_S:  imm = {{20{i[31]}}, i[31:25], i[11:7]};
         INST_B:  imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         INST_U:  imm = {i[31:12], 12'h000};
         INST_J:  imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshakes of the decode queue.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid && ready; the producer holds its data stable while valid is high and
// not yet accepted, and ready never depends combinationally on valid.
interface decode_queue_if #(
   parameter int DEPTH     = 4,
   parameter int BIT_WIDTH = 32,
   parameter int PC_W      = 32
) ();
   import rv32ima_pkg::*;

   logic                         flush;
   logic                         in_valid;
   logic                         in_ready;
   logic [BIT_WIDTH-1:0]         in_inst;
   logic [PC_W-1:0]              in_pc;
   logic                         out_valid;
   logic                         out_ready;
   logic [PC_W-1:0]              out_pc;
   logic [BIT_WIDTH-1:0]         out_inst;
   alu_cmd_t                     out_alu_cmd;
   rf_cmd_t                      out_rf_cmd;
   dmem_cmd_t                    out_dmem_cmd;
   bcontrol_t                    out_control_type;
   inst_t                        out_inst_type;
   logic [BIT_WIDTH-1:0]         out_imm32;
   logic                         out_illegal;
   logic [$clog2(DEPTH+1)-1:0]   count;

   // Environment side: fetch producer, execute consumer and redirect source
   modport master (
      output flush, in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_alu_cmd, out_rf_cmd,
             out_dmem_cmd, out_control_type, out_inst_type, out_imm32,
             out_illegal, count
   );

   // Queue side
   modport slave (
      input  flush, in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_alu_cmd, out_rf_cmd,
             out_dmem_cmd, out_control_type, out_inst_type, out_imm32,
             out_illegal, count
   );

endinterface

// File: rtl/rv32ima_decode_core.sv
// Purely combinational RV32IMA decoder: raw instruction in, full command
// bundle out. Illegal encodings are flagged and stripped of side effects.
module rv32ima_decode_core
   import rv32ima_pkg::*;
(
   input  word_t         inst_i,
   output decoded_inst_t dec_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] funct5;
   decoded_inst_t dec;
   logic illegal;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];
   assign funct5 = inst_i[31:27];

   // Field decode by opcode, then legality masking of side effects
   always_comb begin
      dec                = '0;
      dec.alu.aluop      = ALU_ADD;
      dec.alu.insel      = INSEL_R2R;
      dec.rf.rs1         = inst_i[19:15];
      dec.rf.rs2         = inst_i[24:20];
      dec.rf.rd          = inst_i[11:7];
      dec.rf.wsel        = WSEL_ALU;
      dec.control        = CTRL_NONE;
      dec.inst_type      = INST_R;
      illegal            = (inst_i[1:0] != 2'b11);

      case (opcode)
         OPC_LUI: begin
            dec.inst_type = INST_U;
            dec.alu.insel = INSEL_Z2I;
            dec.rf.wen    = 1'b1;
         end
         OPC_AUIPC: begin
            dec.inst_type = INST_U;
            dec.alu.insel = INSEL_PC2I;
            dec.rf.wen    = 1'b1;
         end
         OPC_JAL: begin
            dec.inst_type = INST_J;
            dec.alu.insel = INSEL_PC2I;
            dec.control   = CTRL_JAL;
            dec.rf.wen    = 1'b1;
            dec.rf.wsel   = WSEL_PC4;
         end
         OPC_JALR: begin
            dec.inst_type = INST_I;
            dec.alu.insel = INSEL_R2I;
            dec.control   = CTRL_JALR;
            dec.rf.wen    = 1'b1;
            dec.rf.wsel   = WSEL_PC4;
            if (funct3 != 3'b000) illegal = 1'b1;
         end
         OPC_BRANCH: begin
            dec.inst_type = INST_B;
            case (funct3)
               3'b000:  dec.control = CTRL_BEQ;
               3'b001:  dec.control = CTRL_BNE;
               3'b100:  dec.control = CTRL_BLT;
               3'b101:  dec.control = CTRL_BGE;
               3'b110:  dec.control = CTRL_BLTU;
               3'b111:  dec.control = CTRL_BGEU;
               default: illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec.inst_type          = INST_I;
            dec.alu.insel          = INSEL_R2I;
            dec.dmem.ren           = 1'b1;
            dec.dmem.load_unsigned = funct3[2];
            dec.dmem.width         = funct3[1:0];
            dec.rf.wen             = 1'b1;
            dec.rf.wsel            = WSEL_MEM;
            case (funct3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
               default: illegal = 1'b1;
            endcase
         end
         OPC_STORE: begin
            dec.inst_type  = INST_S;
            dec.alu.insel  = INSEL_R2I;
            dec.dmem.wen   = 1'b1;
            dec.dmem.width = funct3[1:0];
            if (funct3 > 3'b010) illegal = 1'b1;
         end
         OPC_OPIMM: begin
            dec.inst_type = INST_I;
            dec.alu.insel = INSEL_R2I;
            dec.rf.wen    = 1'b1;
            case (funct3)
               3'b000: dec.alu.aluop = ALU_ADD;
               3'b010: dec.alu.aluop = ALU_SLT;
               3'b011: dec.alu.aluop = ALU_SLTU;
               3'b100: dec.alu.aluop = ALU_XOR;
               3'b110: dec.alu.aluop = ALU_OR;
               3'b111: dec.alu.aluop = ALU_AND;
               3'b001: begin
                  dec.alu.aluop = ALU_SLL;
                  if (funct7 != F7_BASE) illegal = 1'b1;
               end
               default: begin
                  if (funct7 == F7_BASE)     dec.alu.aluop = ALU_SRL;
                  else if (funct7 == F7_ALT) dec.alu.aluop = ALU_SRA;
                  else                       illegal = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            dec.inst_type = INST_R;
            dec.rf.wen    = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  3'b000:  dec.alu.aluop = ALU_ADD;
                  3'b001:  dec.alu.aluop = ALU_SLL;
                  3'b010:  dec.alu.aluop = ALU_SLT;
                  3'b011:  dec.alu.aluop = ALU_SLTU;
                  3'b100:  dec.alu.aluop = ALU_XOR;
                  3'b101:  dec.alu.aluop = ALU_SRL;
                  3'b110:  dec.alu.aluop = ALU_OR;
                  default: dec.alu.aluop = ALU_AND;
               endcase
            end else if (funct7 == F7_ALT) begin
               case (funct3)
                  3'b000:  dec.alu.aluop = ALU_SUB;
                  3'b101:  dec.alu.aluop = ALU_SRA;
                  default: illegal = 1'b1;
               endcase
            end else if (funct7 == F7_MULDIV) begin
               case (funct3)
                  3'b000:  dec.alu.aluop = ALU_MUL;
                  3'b001:  dec.alu.aluop = ALU_MULH;
                  3'b010:  dec.alu.aluop = ALU_MULHSU;
                  3'b011:  dec.alu.aluop = ALU_MULHU;
                  3'b100:  dec.alu.aluop = ALU_DIV;
                  3'b101:  dec.alu.aluop = ALU_DIVU;
                  3'b110:  dec.alu.aluop = ALU_REM;
                  default: dec.alu.aluop = ALU_REMU;
               endcase
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_MISCMEM: begin
            dec.inst_type = INST_I;
            dec.control   = CTRL_FENCE;
            if (funct3 != 3'b000) illegal = 1'b1;
         end
         OPC_SYSTEM: begin
            // Only ECALL/EBREAK exist without Zicsr
            dec.inst_type = INST_I;
            if (inst_i[19:7] != 13'd0)            illegal = 1'b1;
            else if (inst_i[31:20] == 12'h000)    dec.control = CTRL_ECALL;
            else if (inst_i[31:20] == 12'h001)    dec.control = CTRL_EBREAK;
            else                                  illegal = 1'b1;
         end
         OPC_AMO: begin
            // Address is rs1 alone; the aluop merges loaded data with rs2
            dec.inst_type  = INST_R;
            dec.dmem.width = 2'b10;
            dec.rf.wen     = 1'b1;
            dec.rf.wsel    = WSEL_MEM;
            dec.dmem.ren   = 1'b1;
            dec.dmem.wen   = 1'b1;
            if (funct3 != F3_AMO_W) illegal = 1'b1;
            case (funct5)
               F5_LR: begin
                  dec.dmem.wen = 1'b0;
                  if (inst_i[24:20] != 5'd0) illegal = 1'b1;
               end
               F5_SC:      dec.dmem.ren  = 1'b0;
               F5_AMOSWAP: dec.alu.aluop = ALU_SWAP;
               F5_AMOADD:  dec.alu.aluop = ALU_ADD;
               F5_AMOXOR:  dec.alu.aluop = ALU_XOR;
               F5_AMOAND:  dec.alu.aluop = ALU_AND;
               F5_AMOOR:   dec.alu.aluop = ALU_OR;
               F5_AMOMIN:  dec.alu.aluop = ALU_MIN;
               F5_AMOMAX:  dec.alu.aluop = ALU_MAX;
               F5_AMOMINU: dec.alu.aluop = ALU_MINU;
               F5_AMOMAXU: dec.alu.aluop = ALU_MAXU;
               default:    illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase

      dec.imm32 = imm_gen(inst_i[31:7], dec.inst_type);

      if (illegal) begin
         dec.rf.wen    = 1'b0;
         dec.dmem.wen  = 1'b0;
         dec.dmem.ren  = 1'b0;
         dec.control   = CTRL_NONE;
         dec.alu.aluop = ALU_ADD;
      end
      dec.illegal = illegal;
   end

   assign dec_o = dec;

endmodule

// File: rtl/decode_queue.sv
// Decode stage with an instruction buffer: decodes on enqueue, holds DEPTH
// decoded entries in a FIFO and presents the head to execute. Flush drops
// everything for branch redirects.
module decode_queue
   import rv32ima_pkg::*;
#(
   parameter int DEPTH     = 4,    // power of two, >= 2
   parameter int BIT_WIDTH = 32,   // must equal XLEN for the decoder
   parameter int PC_W      = 32
) (
   input logic           clk,
   input logic           rst,
   decode_queue_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   decoded_inst_t        dec_mem  [DEPTH];
   logic [PC_W-1:0]      pc_mem   [DEPTH];
   logic [BIT_WIDTH-1:0] inst_mem [DEPTH];

   decoded_inst_t in_dec;
   logic          in_ready;
   logic          out_valid;
   logic          push;
   logic          pop;

   rv32ima_decode_core u_decode (
      .inst_i (bus.in_inst),
      .dec_o  (in_dec)
   );

   // Handshake flags depend only on registered count; no full-bypass
   assign in_ready  = (count_q != CNT_FULL);
   assign out_valid = (count_q != '0);
   assign push      = bus.in_valid && in_ready;
   assign pop       = out_valid && bus.out_ready;

   // Pointer and occupancy next state; flush wins over push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Pointer and occupancy registers; reset has priority over flush
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, unreset; a push discarded by flush/reset is not written
   always_ff @(posedge clk) begin
      if (push && !bus.flush && !rst) begin
         dec_mem[wr_ptr_q]  <= in_dec;
         pc_mem[wr_ptr_q]   <= bus.in_pc;
         inst_mem[wr_ptr_q] <= bus.in_inst;
      end
   end

   assign bus.in_ready         = in_ready;
   assign bus.out_valid        = out_valid;
   assign bus.count            = count_q;
   assign bus.out_pc           = pc_mem[rd_ptr_q];
   assign bus.out_inst         = inst_mem[rd_ptr_q];
   assign bus.out_alu_cmd      = dec_mem[rd_ptr_q].alu;
   assign bus.out_rf_cmd       = dec_mem[rd_ptr_q].rf;
   assign bus.out_dmem_cmd     = dec_mem[rd_ptr_q].dmem;
   assign bus.out_control_type = dec_mem[rd_ptr_q].control;
   assign bus.out_inst_type    = dec_mem[rd_ptr_q].inst_type;
   assign bus.out_imm32        = dec_mem[rd_ptr_q].imm32;
   assign bus.out_illegal      = dec_mem[rd_ptr_q].illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: handshake, ordering, flush, reset and
// decoder fields against hand-encoded instructions.
module tb_decode_queue;
   import rv32ima_pkg::*;

   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   logic [31:0] exp_q[$];

   decode_queue_if #(.DEPTH(DEPTH), .BIT_WIDTH(32), .PC_W(32)) bus ();

   decode_queue #(.DEPTH(DEPTH), .BIT_WIDTH(32), .PC_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Driver tasks: inputs change just after the falling edge
   task automatic idle_inputs();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_inst   = 32'h0000_0013;
      bus.in_pc     = 32'h0;
      bus.out_ready = 1'b0;
   endtask

   task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
      bus.in_valid  = 1'b1;
      bus.in_inst   = inst;
      bus.in_pc     = pc;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid  = 1'b0;
   endtask

   task automatic pop_one();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_total++;
      if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.count);
      else n_pass++;
      n_total++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      else n_pass++;
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_single_push();
      push_one(32'hFFF0_0093, 32'h0000_0100);
      n_total++;
      if (bus.out_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", bus.out_valid);
      else n_pass++;
      n_total++;
      if (bus.out_rf_cmd.rd !== 5'd1 || bus.out_rf_cmd.rs1 !== 5'd0 || bus.out_rf_cmd.wen !== 1'b1)
         $display("FAIL addi_rf: got rd=%0d rs1=%0d wen=%b want rd=1 rs1=0 wen=1",
                  bus.out_rf_cmd.rd, bus.out_rf_cmd.rs1, bus.out_rf_cmd.wen);
      else n_pass++;
      n_total++;
      if (bus.out_alu_cmd.insel !== INSEL_R2I || bus.out_alu_cmd.aluop !== ALU_ADD)
         $display("FAIL addi_alu: got insel=%0d aluop=%0d want insel=%0d aluop=%0d",
                  bus.out_alu_cmd.insel, bus.out_alu_cmd.aluop, INSEL_R2I, ALU_ADD);
      else n_pass++;
      n_total++;
      if (bus.out_imm32 !== 32'hFFFF_FFFF) $display("FAIL addi_imm: got %h want ffffffff", bus.out_imm32);
      else n_pass++;
      n_total++;
      if (bus.out_illegal !== 1'b0 || bus.count !== 3'd1 || bus.out_pc !== 32'h100)
         $display("FAIL addi_misc: got illegal=%b count=%0d pc=%h want 0 1 00000100",
                  bus.out_illegal, bus.count, bus.out_pc);
      else n_pass++;
      pop_one();
      n_total++;
      if (bus.count !== 3'd0) $display("FAIL addi_drain: got count %0d want 0", bus.count);
      else n_pass++;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) push_one(32'h0000_0013, 32'h200 + 32'(4 * i));
      n_total++;
      if (bus.count !== 3'd4 || bus.in_ready !== 1'b0)
         $display("FAIL full_state: got count=%0d in_ready=%b want 4 0", bus.count, bus.in_ready);
      else n_pass++;
      push_one(32'h0000_0013, 32'h999);
      n_total++;
      if (bus.count !== 3'd4) $display("FAIL full_reject: got count %0d want 4", bus.count);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 + 32'(4 * i))
            $display("FAIL drain_order[%0d]: got valid=%b pc=%h want 1 %h",
                     i, bus.out_valid, bus.out_pc, 32'h200 + 32'(4 * i));
         else n_pass++;
         pop_one();
      end
      n_total++;
      if (bus.count !== 3'd0 || bus.out_valid !== 1'b0)
         $display("FAIL drain_empty: got count=%0d valid=%b want 0 0", bus.count, bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] next_pc;
      exp_q.delete();
      push_one(32'h0000_0013, 32'h300);
      push_one(32'h0000_0013, 32'h304);
      exp_q.push_back(32'h300);
      exp_q.push_back(32'h304);
      next_pc = 32'h308;
      for (int k = 0; k < 10; k++) begin
         bus.in_valid  = 1'b1;
         bus.in_pc     = next_pc;
         bus.out_ready = 1'b1;
         n_total++;
         if (bus.out_pc !== exp_q[0]) $display("FAIL b2b_order[%0d]: got %h want %h", k, bus.out_pc, exp_q[0]);
         else n_pass++;
         @(negedge clk);
         void'(exp_q.pop_front());
         exp_q.push_back(next_pc);
         next_pc = next_pc + 32'd4;
         n_total++;
         if (bus.count !== 3'd2) $display("FAIL b2b_count[%0d]: got %0d want 2", k, bus.count);
         else n_pass++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      while (exp_q.size() > 0) begin
         n_total++;
         if (bus.out_pc !== exp_q[0]) $display("FAIL b2b_tail: got %h want %h", bus.out_pc, exp_q[0]);
         else n_pass++;
         void'(exp_q.pop_front());
         pop_one();
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) push_one(32'h0000_0013, 32'h400 + 32'(4 * i));
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_pc     = 32'hBAD;
      bus.out_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      n_total++;
      if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL flush_state: got count=%0d valid=%b ready=%b want 0 0 1",
                  bus.count, bus.out_valid, bus.in_ready);
      else n_pass++;
      push_one(32'h0010_0093, 32'h500);
      n_total++;
      if (bus.count !== 3'd1 || bus.out_pc !== 32'h500 || bus.out_valid !== 1'b1)
         $display("FAIL flush_next: got count=%0d pc=%h valid=%b want 1 00000500 1",
                  bus.count, bus.out_pc, bus.out_valid);
      else n_pass++;
      pop_one();
   endtask

   task automatic test_illegal_then_mul();
      push_one(32'h0000_0000, 32'h600);
      push_one(32'h0220_81B3, 32'h604);
      n_total++;
      if (bus.out_pc !== 32'h600 || bus.out_illegal !== 1'b1)
         $display("FAIL zero_illegal: got pc=%h illegal=%b want 00000600 1", bus.out_pc, bus.out_illegal);
      else n_pass++;
      n_total++;
      if (bus.out_rf_cmd.wen !== 1'b0 || bus.out_dmem_cmd.wen !== 1'b0 ||
          bus.out_dmem_cmd.ren !== 1'b0 || bus.out_control_type !== CTRL_NONE)
         $display("FAIL zero_effects: got rfwen=%b dwen=%b dren=%b ctrl=%0d want 0 0 0 0",
                  bus.out_rf_cmd.wen, bus.out_dmem_cmd.wen, bus.out_dmem_cmd.ren, bus.out_control_type);
      else n_pass++;
      pop_one();
      n_total++;
      if (bus.out_illegal !== 1'b0 || bus.out_alu_cmd.aluop !== ALU_MUL)
         $display("FAIL mul_alu: got illegal=%b aluop=%0d want 0 %0d",
                  bus.out_illegal, bus.out_alu_cmd.aluop, ALU_MUL);
      else n_pass++;
      n_total++;
      if (bus.out_rf_cmd.rd !== 5'd3 || bus.out_rf_cmd.rs1 !== 5'd1 ||
          bus.out_rf_cmd.rs2 !== 5'd2 || bus.out_rf_cmd.wen !== 1'b1)
         $display("FAIL mul_rf: got rd=%0d rs1=%0d rs2=%0d wen=%b want 3 1 2 1",
                  bus.out_rf_cmd.rd, bus.out_rf_cmd.rs1, bus.out_rf_cmd.rs2, bus.out_rf_cmd.wen);
      else n_pass++;
      pop_one();
   endtask

   typedef struct {
      logic [31:0] inst;
      logic        ill;
      logic        rf_wen;
      logic        dm_wen;
      logic        dm_ren;
      logic [31:0] imm;
      bcontrol_t   ctrl;
   } vec_t;

   task automatic test_decode_table();
      vec_t tbl[12];
      tbl[0]  = '{32'hFE51_2E23, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, CTRL_NONE};   // sw x5,-4(x2)
      tbl[1]  = '{32'hFE20_8CE3, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, CTRL_BEQ};    // beq x1,x2,-8
      tbl[2]  = '{32'h1234_52B7, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5000, CTRL_NONE};   // lui x5
      tbl[3]  = '{32'h0080_00EF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, CTRL_JAL};    // jal x1,+8
      tbl[4]  = '{32'h0080_C303, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0008, CTRL_NONE};   // lbu x6,8(x1)
      tbl[5]  = '{32'h0020_A3AF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, CTRL_NONE};   // amoadd.w
      tbl[6]  = '{32'h0020_B3AF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, CTRL_NONE};   // amo, width d
      tbl[7]  = '{32'h0000_0073, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, CTRL_ECALL};  // ecall
      tbl[8]  = '{32'h0010_0073, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, CTRL_EBREAK}; // ebreak
      tbl[9]  = '{32'h4000_1033, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, CTRL_NONE};   // sll, bad funct7
      tbl[10] = '{32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, CTRL_NONE};   // low bits 00
      tbl[11] = '{32'h4030_D093, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0403, CTRL_NONE};   // srai x1,x1,3
      for (int i = 0; i < 12; i++) begin
         push_one(tbl[i].inst, 32'h800 + 32'(4 * i));
         n_total++;
         if (bus.out_illegal !== tbl[i].ill || bus.out_rf_cmd.wen !== tbl[i].rf_wen)
            $display("FAIL dec_flags[%0d]: got illegal=%b rfwen=%b want %b %b",
                     i, bus.out_illegal, bus.out_rf_cmd.wen, tbl[i].ill, tbl[i].rf_wen);
         else n_pass++;
         n_total++;
         if (bus.out_dmem_cmd.wen !== tbl[i].dm_wen || bus.out_dmem_cmd.ren !== tbl[i].dm_ren)
            $display("FAIL dec_dmem[%0d]: got wen=%b ren=%b want %b %b",
                     i, bus.out_dmem_cmd.wen, bus.out_dmem_cmd.ren, tbl[i].dm_wen, tbl[i].dm_ren);
         else n_pass++;
         n_total++;
         if (bus.out_control_type !== tbl[i].ctrl)
            $display("FAIL dec_ctrl[%0d]: got %0d want %0d", i, bus.out_control_type, tbl[i].ctrl);
         else n_pass++;
         if (!tbl[i].ill) begin
            n_total++;
            if (bus.out_imm32 !== tbl[i].imm)
               $display("FAIL dec_imm[%0d]: got %h want %h", i, bus.out_imm32, tbl[i].imm);
            else n_pass++;
         end
         pop_one();
      end
   endtask

   task automatic test_reset_midstream();
      push_one(32'h0000_0013, 32'h900);
      push_one(32'h0000_0013, 32'h904);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++;
      if (bus.count !== 3'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL rst_mid_state: got count=%0d ready=%b valid=%b want 0 1 0",
                  bus.count, bus.in_ready, bus.out_valid);
      else n_pass++;
      push_one(32'hFFF0_0093, 32'h700);
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h700 || bus.out_imm32 !== 32'hFFFF_FFFF ||
          bus.out_rf_cmd.rd !== 5'd1 || bus.count !== 3'd1)
         $display("FAIL rst_mid_push: got valid=%b pc=%h imm=%h rd=%0d count=%0d want 1 00000700 ffffffff 1 1",
                  bus.out_valid, bus.out_pc, bus.out_imm32, bus.out_rf_cmd.rd, bus.count);
      else n_pass++;
      pop_one();
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst     = 1'b1;
      idle_inputs();
      test_reset();
      test_single_push();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_illegal_then_mul();
      test_decode_table();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
